// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer that serialises read/write requests into the 8x8 memory unit.
// Ties are round-robin by default; define MEM_ARB_FIXED_PRIO_EN to make port 0 win every tie.
module mem_arbiter #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_op,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_op,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_op,
    output logic              mem_select,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);
    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (MEM_LAT > 2) ? CNT_W'(MEM_LAT - 2) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              port_q, port_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_select_q, mem_select_d;
    logic              r0_ack_q, r0_ack_d;
    logic              r1_ack_q, r1_ack_d;
    logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
    logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
    logic              busy_q, busy_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic              last_grant_q, last_grant_d;
`endif
    logic              grant_s;
    logic              enter_resp_s;

    // Winner among the currently requesting ports.
    always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (r0_req) begin
            grant_s = 1'b0;
        end else begin
            grant_s = 1'b1;
        end
`else
        if (r0_req && r1_req) begin
            grant_s = ~last_grant_q;
        end else if (r0_req) begin
            grant_s = 1'b0;
        end else begin
            grant_s = 1'b1;
        end
`endif
    end

    // Sequencer next state plus next values of every registered output.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        port_d       = port_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_select_d = 1'b0;
        enter_resp_s = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    state_d      = ISSUE;
                    port_d       = grant_s;
                    op_d         = grant_s ? r1_op    : r0_op;
                    addr_d       = grant_s ? r1_addr  : r0_addr;
                    wdata_d      = grant_s ? r1_wdata : r0_wdata;
                    mem_select_d = 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_grant_d = grant_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (MEM_LAT == 1) begin
                    state_d      = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d      = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ack and read capture land on the same edge, so rdata is valid with the ack.
        r0_ack_d = enter_resp_s && !port_q;
        r1_ack_d = enter_resp_s && port_q;
        if (enter_resp_s && !op_q) begin
            if (port_q) begin
                r0_rdata_d = r0_rdata_q;
                r1_rdata_d = mem_data_out;
            end else begin
                r0_rdata_d = mem_data_out;
                r1_rdata_d = r1_rdata_q;
            end
        end else begin
            r0_rdata_d = r0_rdata_q;
            r1_rdata_d = r1_rdata_q;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            port_q       <= 1'b0;
            op_q         <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            mem_select_q <= 1'b0;
            r0_ack_q     <= 1'b0;
            r1_ack_q     <= 1'b0;
            r0_rdata_q   <= {DATA_W{1'b0}};
            r1_rdata_q   <= {DATA_W{1'b0}};
            busy_q       <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_select_q <= mem_select_d;
            r0_ack_q     <= r0_ack_d;
            r1_ack_q     <= r1_ack_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
            busy_q       <= busy_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign r0_ack      = r0_ack_q;
    assign r1_ack      = r1_ack_q;
    assign r0_rdata    = r0_rdata_q;
    assign r1_rdata    = r1_rdata_q;
    assign mem_op      = op_q;
    assign mem_select  = mem_select_q;
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT 2, 1, 4) each with a latency-accurate memory
// and a transaction-timeline reference model compared every cycle, plus directed literal checks.
module tb_mem_arbiter;
    localparam int N  = 3;
    localparam int AW = 3;
    localparam int DW = 8;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]         rst_v, r0_req_v, r0_op_v, r1_req_v, r1_op_v;
    logic [N-1:0][AW-1:0] r0_addr_p, r1_addr_p, mem_addr_p;
    logic [N-1:0][DW-1:0] r0_wdata_p, r1_wdata_p, r0_rdata_p, r1_rdata_p, mem_din_p, mem_dout_p;
    logic [N-1:0]         r0_ack_v, r1_ack_v, mem_op_v, mem_sel_v, busy_v;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : inst
        localparam int LAT = lat_of(g);

        mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
            .clk(clk), .rst(rst_v[g]),
            .r0_req(r0_req_v[g]), .r0_op(r0_op_v[g]), .r0_addr(r0_addr_p[g]), .r0_wdata(r0_wdata_p[g]),
            .r0_ack(r0_ack_v[g]), .r0_rdata(r0_rdata_p[g]),
            .r1_req(r1_req_v[g]), .r1_op(r1_op_v[g]), .r1_addr(r1_addr_p[g]), .r1_wdata(r1_wdata_p[g]),
            .r1_ack(r1_ack_v[g]), .r1_rdata(r1_rdata_p[g]),
            .mem_op(mem_op_v[g]), .mem_select(mem_sel_v[g]), .mem_addr(mem_addr_p[g]),
            .mem_data_in(mem_din_p[g]), .mem_data_out(mem_dout_p[g]), .busy(busy_v[g])
        );

        // Memory unit: data_out valid in the LAT-th cycle counting the select cycle, 0xEE before that.
        logic [DW-1:0] mem [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        logic          pend = 1'b0;
        int            scnt = 0;
        always @(posedge clk) begin
            if (mem_sel_v[g]) begin
                pend <= 1'b1;
                scnt <= 1;
                if (mem_op_v[g]) mem[mem_addr_p[g]] <= mem_din_p[g];
            end else if (pend && scnt < 16) begin
                scnt <= scnt + 1;
            end
        end
        assign mem_dout_p[g] = ((mem_sel_v[g] && LAT == 1) || (pend && scnt >= LAT - 1))
                               ? mem[mem_addr_p[g]] : 8'hEE;

        // Reference model: a grant at edge t puts select in cycle t+1, ack in cycle t+LAT+1,
        // and the next grant can happen no earlier than edge t+LAT+2.
        initial begin : model
            int            phase;
            bit            started, last, port, op, a0, a1, sel, bsy, q0, q1;
            logic [AW-1:0] addr;
            logic [DW-1:0] wd, rd0, rd1;
            logic [DW-1:0] shadow [8];
            logic [31:0]   exp_vec, act_vec;
            started = 1'b0; phase = 0; last = 1'b1; port = 1'b0; op = 1'b0;
            addr = '0; wd = '0; rd0 = '0; rd1 = '0; bsy = 1'b0;
            for (int k = 0; k < 8; k++) shadow[k] = 8'h10 + 8'(k);
            forever begin
                @(posedge clk);
                q0 = r0_req_v[g];
                q1 = r1_req_v[g];
                a0 = 1'b0; a1 = 1'b0; sel = 1'b0;
                if (rst_v[g]) begin
                    started = 1'b1; phase = 0; last = 1'b1;
                    op = 1'b0; addr = '0; wd = '0; rd0 = '0; rd1 = '0; bsy = 1'b0;
                end else if (phase == 0) begin
                    if (q0 || q1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                        port = q0 ? 1'b0 : 1'b1;
`else
                        if (q0 && q1) port = (last == 1'b0) ? 1'b1 : 1'b0;
                        else          port = q0 ? 1'b0 : 1'b1;
`endif
                        last  = port;
                        op    = port ? r1_op_v[g]    : r0_op_v[g];
                        addr  = port ? r1_addr_p[g]  : r0_addr_p[g];
                        wd    = port ? r1_wdata_p[g] : r0_wdata_p[g];
                        if (op) shadow[addr] = wd;
                        phase = 1; sel = 1'b1; bsy = 1'b1;
                    end else begin
                        bsy = 1'b0;
                    end
                end else begin
                    phase++;
                    if (phase == LAT + 1) begin
                        if (port) a1 = 1'b1; else a0 = 1'b1;
                        if (!op) begin
                            if (port) rd1 = shadow[addr]; else rd0 = shadow[addr];
                        end
                    end
                    if (phase == LAT + 2) begin
                        phase = 0; bsy = 1'b0;
                    end else begin
                        bsy = 1'b1;
                    end
                end
                @(negedge clk);
                if (started) begin
                    exp_vec = {a0, a1, rd0, rd1, sel, op, addr, wd, bsy};
                    act_vec = {r0_ack_v[g], r1_ack_v[g], r0_rdata_p[g], r1_rdata_p[g], mem_sel_v[g],
                               mem_op_v[g], mem_addr_p[g], mem_din_p[g], busy_v[g]};
                    chk($sformatf("model[%0d] outputs", g), act_vec, exp_vec);
                end
            end
        end
    end

    task automatic set_req(input int i, input int p, input bit op, input int addr, input int wd);
        if (p == 0) begin
            r0_req_v[i] = 1'b1; r0_op_v[i] = op; r0_addr_p[i] = AW'(addr); r0_wdata_p[i] = DW'(wd);
        end else begin
            r1_req_v[i] = 1'b1; r1_op_v[i] = op; r1_addr_p[i] = AW'(addr); r1_wdata_p[i] = DW'(wd);
        end
    endtask

    task automatic clr_req(input int i, input int p);
        if (p == 0) r0_req_v[i] = 1'b0;
        else        r1_req_v[i] = 1'b0;
    endtask

    // Count negedges until the port's ack is seen; -1 if it never comes.
    task automatic wait_ack(input int i, input int p, output int lat);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = (p == 0) ? r0_ack_v[i] : r1_ack_v[i];
        end
        lat = got ? n : -1;
    endtask

    task automatic do_txn(input int i, input int p, input bit op, input int addr, input int wd,
                          input string name);
        int lat;
        set_req(i, p, op, addr, wd);
        wait_ack(i, p, lat);
        clr_req(i, p);
        chk({name, " ack latency"}, 32'(lat), 32'(lat_of(i) + 1));
        @(negedge clk);
    endtask

    initial begin
        int lat, n;
        bit got;
        rst_v = '1; r0_req_v = '0; r1_req_v = '0; r0_op_v = '0; r1_op_v = '0;
        r0_addr_p = '0; r1_addr_p = '0; r0_wdata_p = '0; r1_wdata_p = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy_v), 32'd0);
        chk("reset acks", 32'({r0_ack_v, r1_ack_v}), 32'd0);
        chk("reset select", 32'(mem_sel_v), 32'd0);
        chk("reset rdata", 32'({r0_rdata_p[0], r1_rdata_p[0]}), 32'd0);
        rst_v = '0;
        @(negedge clk);

        // Port 0 write 0xA5 to addr 3.
        set_req(0, 0, 1'b1, 3, 8'hA5);
        @(negedge clk);
        chk("write issue pulse", 32'({mem_sel_v[0], mem_op_v[0], mem_addr_p[0], mem_din_p[0]}),
            32'({1'b1, 1'b1, 3'd3, 8'hA5}));
        wait_ack(0, 0, lat);
        clr_req(0, 0);
        chk("write ack latency", 32'(lat + 1), 32'd3);
        chk("write leaves rdata", 32'(r0_rdata_p[0]), 32'h00);
        @(negedge clk);
        chk("select single pulse", 32'(mem_sel_v[0]), 32'd0);

        // Port 1 reads it back.
        do_txn(0, 1, 1'b0, 3, 0, "read back");
        chk("read back data", 32'(r1_rdata_p[0]), 32'hA5);
        chk("other port rdata", 32'(r0_rdata_p[0]), 32'h00);

        // Both ports request continuously.
        set_req(0, 0, 1'b0, 1, 0);
        set_req(0, 1, 1'b0, 2, 0);
        for (int k = 0; k < 8; k++) begin
            n = 0; got = 1'b0;
            while (!got && n < 20) begin
                @(negedge clk);
                n++;
                got = r0_ack_v[0] | r1_ack_v[0];
            end
            chk($sformatf("contend ack %0d seen", k), 32'(got), 32'd1);
            chk($sformatf("contend ack %0d single", k), 32'(r0_ack_v[0] & r1_ack_v[0]), 32'd0);
`ifdef MEM_ARB_FIXED_PRIO_EN
            chk($sformatf("contend ack %0d port", k), 32'(r1_ack_v[0]), 32'd0);
`else
            chk($sformatf("contend ack %0d port", k), 32'(r1_ack_v[0]), 32'(k % 2));
`endif
            chk($sformatf("contend ack %0d spacing", k), 32'(n), (k == 0) ? 32'd3 : 32'd4);
        end
        clr_req(0, 0);
        clr_req(0, 1);
        chk("contend rdata0", 32'(r0_rdata_p[0]), 32'h11);
`ifdef MEM_ARB_FIXED_PRIO_EN
        chk("contend rdata1", 32'(r1_rdata_p[0]), 32'hA5);
`else
        chk("contend rdata1", 32'(r1_rdata_p[0]), 32'h12);
`endif
        repeat (2) @(negedge clk);

        // Reset while the transaction sits in WAIT; the held request is served afterwards.
        set_req(0, 0, 1'b0, 5, 0);
        repeat (2) @(negedge clk);
        chk("busy in wait", 32'(busy_v[0]), 32'd1);
        rst_v[0] = 1'b1;
        @(negedge clk);
        chk("busy after reset", 32'(busy_v[0]), 32'd0);
        chk("acks after reset", 32'({r0_ack_v[0], r1_ack_v[0]}), 32'd0);
        rst_v[0] = 1'b0;
        wait_ack(0, 0, lat);
        clr_req(0, 0);
        chk("reissue latency", 32'(lat), 32'd3);
        chk("reissue data", 32'(r0_rdata_p[0]), 32'h15);
        @(negedge clk);

        // First tie after reset goes to port 0.
        set_req(1, 0, 1'b0, 4, 0);
        set_req(1, 1, 1'b0, 7, 0);
        wait_ack(1, 0, lat);
        clr_req(1, 0);
        clr_req(1, 1);
        chk("first tie port 0 latency", 32'(lat), 32'd2);
        chk("first tie data", 32'(r0_rdata_p[1]), 32'h14);
        repeat (2) @(negedge clk);

        // Latency sweep: write 0x3C then read it from the other port.
        for (int i = 0; i < N; i++) begin
            do_txn(i, 0, 1'b1, 6, 8'h3C, $sformatf("sweep[%0d] write", i));
            do_txn(i, 1, 1'b0, 6, 0, $sformatf("sweep[%0d] read", i));
            chk($sformatf("sweep[%0d] read data", i), 32'(r1_rdata_p[i]), 32'h3C);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t limit 100000", $time);
        $fatal(1);
    end

endmodule
